// File: rtl/jelly_comm_to_wishbone_pkg.sv
// Shared command/response codes and FSM state type for the comm-to-Wishbone bridge.
package jelly_comm_to_wishbone_pkg;

  localparam logic [7:0] CmdPing    = 8'h00;
  localparam logic [7:0] CmdWrite   = 8'h01;
  localparam logic [7:0] CmdRead    = 8'h02;
  localparam logic [7:0] RspPing    = 8'h80;
  localparam logic [7:0] RspWrite   = 8'h81;
  localparam logic [7:0] RspRead    = 8'h82;
  localparam logic [7:0] RspTimeout = 8'hFE;
  localparam logic [7:0] RspUnknown = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StResp,
    StRdata
  } state_e;

endpackage

// File: rtl/jelly_comm_to_wishbone.sv
// Byte-stream command decoder acting as a single-cycle Wishbone classic master
// for host debug access; status and read data are returned on the tx stream.
module jelly_comm_to_wishbone
  import jelly_comm_to_wishbone_pkg::*;
#(
  parameter int unsigned WB_ADR_WIDTH = 30,
  parameter int unsigned WB_DAT_WIDTH = 32,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic [7:0]                comm_rx_data,
  input  logic                      comm_rx_valid,
  output logic                      comm_rx_ready,
  output logic [7:0]                comm_tx_data,
  output logic                      comm_tx_valid,
  input  logic                      comm_tx_ready,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [WB_ADR_WIDTH-1:0]   wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]   wb_dat_o,
  output logic [WB_DAT_WIDTH/8-1:0] wb_sel_o,
  input  logic [WB_DAT_WIDTH-1:0]   wb_dat_i,
  input  logic                      wb_ack_i
);

  localparam int unsigned ABYTES = (WB_ADR_WIDTH + 7) / 8;
  localparam int unsigned DBYTES = WB_DAT_WIDTH / 8;
  localparam int unsigned AW8    = ABYTES * 8;
  localparam logic [7:0]  ALast  = 8'(ABYTES - 1);
  localparam logic [7:0]  DLast  = 8'(DBYTES - 1);

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [31:0]               timer_q, timer_d;
  logic                      is_write_q, is_write_d;
  logic                      rd_ok_q, rd_ok_d;
  logic [AW8-1:0]            adr_sr_q, adr_sr_d;
  logic [WB_DAT_WIDTH-1:0]   dat_sr_q, dat_sr_d;
  logic [WB_DAT_WIDTH-1:0]   rdat_q, rdat_d;
  logic                      rx_ready_q, rx_ready_d;
  logic                      tx_valid_q, tx_valid_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      cyc_q, cyc_d;
  logic                      we_q, we_d;
  logic [WB_ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0]   wdat_q, wdat_d;

  logic rx_fire, tx_fire, timeout_hit, start_bus;

  assign rx_fire     = comm_rx_valid & rx_ready_q;
  assign tx_fire     = tx_valid_q & comm_tx_ready;
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMEOUT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    is_write_d = is_write_q;
    rd_ok_d    = rd_ok_q;
    adr_sr_d   = adr_sr_q;
    dat_sr_d   = dat_sr_q;
    rdat_d     = rdat_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    start_bus  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          cnt_d   = '0;
          rd_ok_d = 1'b0;
          case (comm_rx_data)
            CmdWrite: begin
              is_write_d = 1'b1;
              state_d    = StAddr;
            end
            CmdRead: begin
              is_write_d = 1'b0;
              state_d    = StAddr;
            end
            CmdPing: begin
              state_d    = StResp;
              tx_valid_d = 1'b1;
              tx_data_d  = RspPing;
            end
            default: begin
              state_d    = StResp;
              tx_valid_d = 1'b1;
              tx_data_d  = RspUnknown;
            end
          endcase
        end
      end
      StAddr: begin
        if (rx_fire) begin
          // Little-endian: each new byte enters at the top and ends up shifted down.
          adr_sr_d = (adr_sr_q >> 8) | (AW8'(comm_rx_data) << (AW8 - 8));
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == ALast) begin
            cnt_d = '0;
            if (is_write_q) state_d = StData;
            else            start_bus = 1'b1;
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          dat_sr_d = (dat_sr_q >> 8) | (WB_DAT_WIDTH'(comm_rx_data) << (WB_DAT_WIDTH - 8));
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == DLast) begin
            cnt_d     = '0;
            start_bus = 1'b1;
          end
        end
      end
      StBus: begin
        timer_d = timer_q + 32'd1;
        if (wb_ack_i) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = is_write_q ? RspWrite : RspRead;
          rdat_d     = wb_dat_i;
          rd_ok_d    = ~is_write_q;
        end else if (timeout_hit) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = RspTimeout;
          rd_ok_d    = 1'b0;
        end
      end
      StResp: begin
        if (tx_fire) begin
          if (rd_ok_q) begin
            state_d   = StRdata;
            tx_data_d = rdat_q[7:0];
            rdat_d    = rdat_q >> 8;
            cnt_d     = '0;
          end else begin
            state_d    = StIdle;
            tx_valid_d = 1'b0;
          end
        end
      end
      StRdata: begin
        if (tx_fire) begin
          if (cnt_q == DLast) begin
            state_d    = StIdle;
            tx_valid_d = 1'b0;
          end else begin
            tx_data_d = rdat_q[7:0];
            rdat_d    = rdat_q >> 8;
            cnt_d     = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_bus) begin
      state_d = StBus;
      cyc_d   = 1'b1;
      we_d    = is_write_q;
      timer_d = '0;
      adr_d   = adr_sr_d[WB_ADR_WIDTH-1:0];
      if (is_write_q) wdat_d = dat_sr_d;
    end

    rx_ready_d = (state_d == StIdle) || (state_d == StAddr) || (state_d == StData);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timer_q    <= '0;
      is_write_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      adr_sr_q   <= '0;
      dat_sr_q   <= '0;
      rdat_q     <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      is_write_q <= is_write_d;
      rd_ok_q    <= rd_ok_d;
      adr_sr_q   <= adr_sr_d;
      dat_sr_q   <= dat_sr_d;
      rdat_q     <= rdat_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
    end
  end

  assign comm_rx_ready = rx_ready_q;
  assign comm_tx_valid = tx_valid_q;
  assign comm_tx_data  = tx_data_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = wdat_q;
  assign wb_sel_o      = '1;

endmodule

// File: tb/tb_jelly_comm_to_wishbone.sv
// Bench for jelly_comm_to_wishbone: command table plus reset corner sequences,
// with tx bytes and Wishbone cycles checked against expectation queues.
module tb_jelly_comm_to_wishbone;

  localparam int unsigned TO = 15;

  logic        reset;
  logic        clk;
  logic [7:0]  comm_rx_data;
  logic        comm_rx_valid;
  logic        comm_rx_ready;
  logic [7:0]  comm_tx_data;
  logic        comm_tx_valid;
  logic        comm_tx_ready = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [29:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'h0BAD_F00D;
  logic        wb_ack_i = 1'b0;

  jelly_comm_to_wishbone #(
    .WB_ADR_WIDTH(30),
    .WB_DAT_WIDTH(32),
    .TIMEOUT     (TO)
  ) dut (
    .reset        (reset),
    .clk          (clk),
    .comm_rx_data (comm_rx_data),
    .comm_rx_valid(comm_rx_valid),
    .comm_rx_ready(comm_rx_ready),
    .comm_tx_data (comm_tx_data),
    .comm_tx_valid(comm_tx_valid),
    .comm_tx_ready(comm_tx_ready),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [31:0] adr;
    logic [31:0] dat;
    int          waits;
    logic        ack_en;
    logic        rand_rdy;
    logic [7:0]  status;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];

  logic        rand_ready   = 1'b0;
  logic        slave_ack_en = 1'b1;
  int          slave_wait   = 0;
  logic [31:0] slave_rdata  = 32'h0;
  int          wcnt         = 0;
  int          cyc_run      = 0;
  int          last_cyc_len = 0;
  logic        tx_hold      = 1'b0;
  logic [7:0]  tx_prev      = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wishbone slave: acks after slave_wait wait states and checks each cycle.
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (slave_ack_en && wcnt == slave_wait) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slave_rdata;
        wcnt     = 0;
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got a Wishbone cycle adr=%0h expected none", wb_adr_o);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          check("bus_we", wb_we_o, e.we);
          check("bus_adr", wb_adr_o, e.adr);
          check("bus_sel", wb_sel_o, 4'hF);
          if (e.we) check("bus_wdat", wb_dat_o, e.dat);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0BAD_F00D;
      if (!wb_cyc_o) wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (wb_cyc_o) begin
      cyc_run++;
    end else begin
      if (cyc_run != 0) last_cyc_len = cyc_run;
      cyc_run = 0;
    end
  end

  // tx monitor; ready chosen here so the handshake at the next posedge is known.
  always @(negedge clk) begin
    if (!reset) begin
      comm_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (comm_tx_valid) begin
        if (tx_hold) check("tx_stable", comm_tx_data, tx_prev);
        if (comm_tx_ready) begin
          tx_hold = 1'b0;
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %0h expected none", comm_tx_data);
          end else begin
            check("tx_byte", comm_tx_data, exp_tx.pop_front());
          end
        end else begin
          tx_hold = 1'b1;
          tx_prev = comm_tx_data;
        end
      end else begin
        tx_hold = 1'b0;
      end
    end else begin
      tx_hold = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    comm_rx_data  = b;
    comm_rx_valid = 1'b1;
    while (!comm_rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: got no ready for byte %0h expected ready", b);
    end
    @(negedge clk);
    comm_rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || comm_tx_valid || wb_cyc_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d tx bytes pending expected 0", name, exp_tx.size());
    end
    @(negedge clk);
    check({name, "_tx_left"}, 64'(exp_tx.size()), 0);
    check({name, "_bus_left"}, 64'(exp_bus.size()), 0);
    exp_tx.delete();
    exp_bus.delete();
  endtask

  task automatic expect_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                            input logic ack_en, input logic [7:0] status);
    bus_t b;
    exp_tx.push_back(status);
    if ((cmd == 8'h01 || cmd == 8'h02) && ack_en) begin
      b.we  = (cmd == 8'h01);
      b.adr = adr[29:0];
      b.dat = dat;
      exp_bus.push_back(b);
    end
    if (status == 8'h82) begin
      for (int k = 0; k < 4; k++) exp_tx.push_back(dat[8*k +: 8]);
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    send_byte(cmd);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      for (int k = 0; k < 4; k++) send_byte(adr[8*k +: 8]);
    end
    if (cmd == 8'h01) begin
      for (int k = 0; k < 4; k++) send_byte(dat[8*k +: 8]);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rx_ready"}, comm_rx_ready, 1'b0);
    check({name, "_tx_valid"}, comm_tx_valid, 1'b0);
    check({name, "_tx_data"}, comm_tx_data, 8'h00);
    check({name, "_cyc"}, wb_cyc_o, 1'b0);
    check({name, "_stb"}, wb_stb_o, 1'b0);
    check({name, "_we"}, wb_we_o, 1'b0);
    check({name, "_adr"}, wb_adr_o, 30'h0);
    check({name, "_dat"}, wb_dat_o, 32'h0);
    check({name, "_sel"}, wb_sel_o, 4'hF);
  endtask

  localparam int NV = 8;
  vec_t vecs[NV];
  vec_t v;

  initial begin
    vecs[0] = '{"ping",     8'h00, 32'h0,         32'h0,         0, 1'b1, 1'b0, 8'h80};
    vecs[1] = '{"write",    8'h01, 32'h3654_3210, 32'h1234_5678, 0, 1'b1, 1'b0, 8'h81};
    vecs[2] = '{"read",     8'h02, 32'h0000_0004, 32'hDEAD_BEEF, 3, 1'b1, 1'b1, 8'h82};
    vecs[3] = '{"timeout",  8'h02, 32'h0000_0100, 32'h0,         0, 1'b0, 1'b0, 8'hFE};
    vecs[4] = '{"ping2",    8'h00, 32'h0,         32'h0,         0, 1'b1, 1'b0, 8'h80};
    vecs[5] = '{"unknown",  8'h55, 32'h0,         32'h0,         0, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{"write_hi", 8'h01, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 0, 1'b1, 1'b1, 8'h81};
    vecs[7] = '{"read_0ws", 8'h02, 32'h0000_1234, 32'h0102_0304, 0, 1'b1, 1'b0, 8'h82};

    reset         = 1'b1;
    comm_rx_valid = 1'b0;
    comm_rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      v            = vecs[i];
      rand_ready   = v.rand_rdy;
      slave_wait   = v.waits;
      slave_ack_en = v.ack_en;
      slave_rdata  = v.dat;
      last_cyc_len = 0;
      expect_cmd(v.cmd, v.adr, v.dat, v.ack_en, v.status);
      send_cmd(v.cmd, v.adr, v.dat);
      wait_done(v.name);
      if (!v.ack_en) check("timeout_cyc_len", 64'(last_cyc_len), 64'(TO + 1));
    end
    rand_ready   = 1'b0;
    slave_ack_en = 1'b1;
    slave_wait   = 0;

    // Reset while write data bytes are still arriving.
    send_byte(8'h01);
    for (int k = 0; k < 4; k++) send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_data");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset while a read cycle is stalled on the bus.
    slave_ack_en = 1'b0;
    send_cmd(8'h02, 32'h0000_0040, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_bus_cyc_before", wb_cyc_o, 1'b1);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_bus");
    @(negedge clk);
    reset = 1'b0;
    exp_tx.delete();
    exp_bus.delete();
    @(negedge clk);

    slave_ack_en = 1'b1;
    slave_wait   = 1;
    slave_rdata  = 32'hCAFE_F00D;
    rand_ready   = 1'b1;
    expect_cmd(8'h02, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 8'h82);
    send_cmd(8'h02, 32'h0000_0010, 32'h0);
    wait_done("read_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
